// File: rtl/tohost_monitor_pkg.sv
// Shared types and constants for the HTIF tohost/fromhost monitor.
// Holds the verdict state encoding, default register addresses and the store byte-merge helper.
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    localparam logic [31:0] DEF_TOHOST_ADDR   = 32'h0000_1000;
    localparam logic [31:0] DEF_FROMHOST_ADDR = 32'h0000_1040;
    localparam logic [31:0] HTIF_PASS         = 32'h0000_0001;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/tohost_monitor_cycle_watchdog.sv
// Saturating cycle counter with an expire flag raised while the count sits one below the limit.
// The count holds on the expiring cycle so the reported value equals limit-1.
module cycle_watchdog #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_limit_m1;
    logic             w_at_max;

    assign w_limit_m1 = i_limit - ONE;
    assign w_at_max   = &r_count;
    assign o_expire   = i_en && (r_count == w_limit_m1);
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && !o_expire && !w_at_max) begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Memory-mapped HTIF tohost/fromhost responder that latches the riscv-tests verdict.
// Decodes data-bus hits, merges stores, answers one cycle later and tracks RUN/DONE/TOUT.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
    parameter logic [31:0] FROMHOST_ADDR  = DEF_FROMHOST_ADDR,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             done,
    output logic             pass,
    output logic [30:0]      fail_num,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_tohost;
    logic [31:0] r_fromhost;
    logic        r_sys_pend;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic        r_pass;
    logic [30:0] r_fail_num;

    logic        w_accept;
    logic        w_hit_to;
    logic        w_hit_from;
    logic        w_hit;
    logic        w_misal;
    logic        w_st_ok;
    logic        w_ld_ok;
    logic [31:0] w_from_cur;
    logic [31:0] w_to_merged;
    logic [31:0] w_from_merged;
    logic [31:0] w_rdata_ld;
    logic        w_to_store;
    logic        w_term;
    logic        w_syscall;
    logic        w_run;
    logic        w_expire;

    // Reset is the only thing that can hold the core off; the block never stalls.
    assign req_ready = rst;

    assign w_accept   = req_valid && req_ready;
    assign w_hit_to   = (req_addr[31:2] == TOHOST_ADDR[31:2]);
    assign w_hit_from = (req_addr[31:2] == FROMHOST_ADDR[31:2]);
    assign w_hit      = w_accept && (w_hit_to || w_hit_from);
    assign w_misal    = (req_addr[1:0] != 2'b00);
    assign w_st_ok    = w_hit && !w_misal && req_we;
    assign w_ld_ok    = w_hit && !w_misal && !req_we;

    // A syscall ack lands in fromhost on the following edge; forward it so a load issued meanwhile sees it.
    assign w_from_cur    = r_sys_pend ? HTIF_PASS : r_fromhost;
    assign w_to_merged   = byte_merge(r_tohost, req_wdata, req_wstrb);
    assign w_from_merged = byte_merge(w_from_cur, req_wdata, req_wstrb);
    assign w_rdata_ld    = w_hit_to ? r_tohost : w_from_cur;

    assign w_run      = (r_state == ST_RUN);
    assign w_to_store = w_st_ok && w_hit_to && w_run;
    assign w_term     = w_to_store && w_to_merged[0];
    assign w_syscall  = w_to_store && !w_to_merged[0] && (w_to_merged != 32'h0);

    cycle_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (w_run),
        .i_limit  (LIMIT),
        .o_count  (cycles),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A terminating store wins over a watchdog expiry in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_term) begin
                    w_state_nxt = ST_DONE;
                end else if (w_expire) begin
                    w_state_nxt = ST_TOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tohost    <= '0;
            r_fromhost  <= '0;
            r_sys_pend  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_pass      <= 1'b0;
            r_fail_num  <= '0;
        end else begin
            r_rsp_valid <= w_hit;
            r_rsp_err   <= w_hit && w_misal;
            r_rsp_rdata <= w_ld_ok ? w_rdata_ld : 32'h0;
            r_sys_pend  <= w_syscall;

            if (w_to_store) begin
                r_tohost <= w_to_merged;
            end

            if (w_st_ok && w_hit_from) begin
                r_fromhost <= w_from_merged;
            end else if (r_sys_pend) begin
                r_fromhost <= HTIF_PASS;
            end

            if (w_term) begin
                r_pass     <= (w_to_merged == HTIF_PASS);
                r_fail_num <= w_to_merged[31:1];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign done      = (r_state == ST_DONE);
    assign timeout   = (r_state == ST_TOUT);
    assign pass      = r_pass;
    assign fail_num  = r_fail_num;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor with a short watchdog limit of 20 cycles.
module tb_tohost_monitor;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [3:0]       req_wstrb;
    logic             req_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             done;
    logic             pass;
    logic [30:0]      fail_num;
    logic             timeout;
    logic [CNT_W-1:0] cycles;

    int n_checks;
    int n_pass;

    tohost_monitor #(
        .TIMEOUT_CYCLES (20),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .done      (done),
        .pass      (pass),
        .fail_num  (fail_num),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
    endtask

    // Called at a negedge; returns at the next negedge with the response visible.
    task automatic bus(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
        set_req(we, addr, wdata, strb);
        @(negedge clk);
        clear_req();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_req();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        clear_req();
        @(negedge clk);

        check("rst_ready",   {31'b0, req_ready}, 32'h0);
        check("rst_rsp",     {31'b0, rsp_valid}, 32'h0);
        check("rst_done",    {31'b0, done},      32'h0);
        check("rst_timeout", {31'b0, timeout},   32'h0);
        check("rst_cycles",  {16'b0, cycles},    32'h0);

        // pass verdict
        do_reset();
        check("ready_run", {31'b0, req_ready}, 32'h1);
        bus(1'b1, 32'h0000_1000, 32'h1, 4'hF);
        check("pass_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("pass_rsp_err",   {31'b0, rsp_err},   32'h0);
        check("pass_done",      {31'b0, done},      32'h1);
        check("pass_pass",      {31'b0, pass},      32'h1);
        check("pass_fail_num",  {1'b0, fail_num},   32'h0);
        check("pass_timeout",   {31'b0, timeout},   32'h0);
        idle(1);
        check("pass_rsp_pulse", {31'b0, rsp_valid}, 32'h0);

        // fail verdict, then sticky
        do_reset();
        bus(1'b1, 32'h0000_1000, 32'h7, 4'hF);
        check("fail_done",     {31'b0, done},    32'h1);
        check("fail_pass",     {31'b0, pass},    32'h0);
        check("fail_num3",     {1'b0, fail_num}, 32'd3);
        bus(1'b1, 32'h0000_1000, 32'h1, 4'hF);
        check("sticky_rsp",    {31'b0, rsp_valid}, 32'h1);
        check("sticky_pass",   {31'b0, pass},      32'h0);
        check("sticky_num",    {1'b0, fail_num},   32'd3);
        bus(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        check("sticky_tohost", rsp_rdata, 32'h7);

        // watchdog timeout at cycle 20
        do_reset();
        idle(19);
        check("tout_pre",        {31'b0, timeout}, 32'h0);
        check("tout_pre_cycles", {16'b0, cycles},  32'd19);
        idle(1);
        check("tout_flag",   {31'b0, timeout}, 32'h1);
        check("tout_done",   {31'b0, done},    32'h0);
        check("tout_cycles", {16'b0, cycles},  32'd19);
        idle(5);
        check("tout_frozen", {16'b0, cycles},  32'd19);

        // terminating store on the expiring cycle
        do_reset();
        idle(19);
        bus(1'b1, 32'h0000_1000, 32'h3, 4'hF);
        check("race_done",    {31'b0, done},    32'h1);
        check("race_timeout", {31'b0, timeout}, 32'h0);
        check("race_num",     {1'b0, fail_num}, 32'd1);
        idle(3);
        check("race_timeout_later", {31'b0, timeout}, 32'h0);

        // misaligned accesses and non-hits
        do_reset();
        bus(1'b0, 32'h0000_1042, 32'h0, 4'h0);
        check("mis_ld_valid", {31'b0, rsp_valid}, 32'h1);
        check("mis_ld_err",   {31'b0, rsp_err},   32'h1);
        check("mis_ld_rdata", rsp_rdata,          32'h0);
        bus(1'b1, 32'h0000_1001, 32'h1, 4'hF);
        check("mis_st_err",   {31'b0, rsp_err},   32'h1);
        check("mis_st_done",  {31'b0, done},      32'h0);
        bus(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        check("mis_tohost",   rsp_rdata,          32'h0);
        check("mis_ok_err",   {31'b0, rsp_err},   32'h0);
        bus(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        check("nohit_valid",  {31'b0, rsp_valid}, 32'h0);

        // zero store, syscall and byte merge
        do_reset();
        bus(1'b1, 32'h0000_1000, 32'h0, 4'hF);
        check("zero_done",    {31'b0, done}, 32'h0);
        bus(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        check("zero_from",    rsp_rdata,     32'h0);
        bus(1'b1, 32'h0000_1000, 32'h10, 4'hF);
        check("sys_done",     {31'b0, done}, 32'h0);
        bus(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        check("sys_from",     rsp_rdata,     32'h1);
        bus(1'b1, 32'h0000_1000, 32'hFF, 4'h1);
        check("merge_done",   {31'b0, done},    32'h1);
        check("merge_num",    {1'b0, fail_num}, 32'd127);
        bus(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        check("merge_tohost", rsp_rdata, 32'h0000_00FF);

        // back-to-back hits
        do_reset();
        set_req(1'b1, 32'h0000_1040, 32'hAB, 4'hF);
        @(negedge clk);
        check("b2b_a_valid", {31'b0, rsp_valid}, 32'h1);
        set_req(1'b0, 32'h0000_1040, 32'h0, 4'h0);
        @(negedge clk);
        check("b2b_b_valid", {31'b0, rsp_valid}, 32'h1);
        check("b2b_b_rdata", rsp_rdata,          32'hAB);
        set_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        @(negedge clk);
        clear_req();
        check("b2b_c_valid", {31'b0, rsp_valid}, 32'h1);
        check("b2b_c_rdata", rsp_rdata,          32'h0);

        // reset during a response
        do_reset();
        set_req(1'b1, 32'h0000_1000, 32'h1, 4'hF);
        @(posedge clk);
        #2;
        check("mid_rsp_before",  {31'b0, rsp_valid}, 32'h1);
        check("mid_done_before", {31'b0, done},      32'h1);
        rst = 1'b0;
        #1;
        check("mid_rsp",    {31'b0, rsp_valid}, 32'h0);
        check("mid_done",   {31'b0, done},      32'h0);
        check("mid_pass",   {31'b0, pass},      32'h0);
        check("mid_cycles", {16'b0, cycles},    32'h0);
        @(negedge clk);
        clear_req();
        rst = 1'b1;
        idle(3);
        check("resume_cycles", {16'b0, cycles},  32'd3);
        check("resume_done",   {31'b0, done},    32'h0);
        bus(1'b1, 32'h0000_1000, 32'h3, 4'hF);
        check("resume_term",   {31'b0, done},    32'h1);
        check("resume_num",    {1'b0, fail_num}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
